audio_pwm_out: RTL
==================

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 Parameter SAMPLE_DIV, default 1250, meaning clk cycles per audio sample (10 MHz / 8 kHz).
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sample_tick  output  1  one-cycle sample strobe; drives the en input of the upstream sample readers.
REQ-005 kick_smp  input  8  kick voice sample, offset-binary; 128 is silence.
REQ-006 snare_smp  input  8  snare voice sample, offset-binary; 128 is silence.
REQ-007 voice_en  input  2  bit0 enables kick, bit1 enables snare.
REQ-008 vol_shift  input  2  attenuation as an arithmetic right shift of 0..3.
REQ-009 mix_out  output  8  current mixed sample, offset-binary.
REQ-010 pwm_out  output  1  registered PWM audio output.

Function
REQ-011 Tick divider SHALL count 0..SAMPLE_DIV-1 and wrap to 0; sample_tick=1 exactly when count==SAMPLE_DIV-1.
REQ-012 First sample_tick SHALL occur SAMPLE_DIV cycles after rst_n deasserts.
REQ-013 Capture SHALL happen on the cycle after sample_tick, so upstream reader outputs updated on the tick edge are taken.
REQ-014 Conversion: each enabled voice SHALL be converted to signed as x-128; a disabled voice SHALL contribute 0.
REQ-015 Sum: the two signed values SHALL be added at 9 bits signed.
REQ-016 Scaling: the sum SHALL be arithmetically shifted right by vol_shift.
REQ-017 Saturation: the scaled sum SHALL saturate to [-128,127].
REQ-018 Output mapping: +128 SHALL be added to the saturated result, and the value registered into mix_out.
REQ-019 mix_out SHALL update exactly 2 cycles after sample_tick and hold until the next update.
REQ-020 PWM counter SHALL be 8-bit and free-running 0..255, wrapping to 0.
REQ-021 pwm_out SHALL be registered (cnt < duty).
REQ-022 duty=0 SHALL give pwm_out constantly 0.
REQ-023 duty=255 SHALL give pwm_out high for 255 of every 256 cycles.
REQ-024 duty SHALL load from mix_out only on the cycle cnt==255, so no mid-period change occurs.
REQ-025 If a mix_out update and cnt==255 coincide, duty SHALL load the old mix_out; the new value loads at the next period boundary.
REQ-026 voice_en and vol_shift changes SHALL take effect at the next capture only.

Reset
REQ-027 On rst_n low, the following SHALL reset asynchronously: tick count 0, PWM count 0, capture strobe 0, sample_tick 0, mix_out 128, duty 128, pwm_out 0.
REQ-028 Reset asserted mid-period or mid-pipeline SHALL discard the in-flight sample; no partial update appears after release.

Configuration
REQ-029 Macro PWM_DITHER_EN defined: an 8-bit Fibonacci LFSR SHALL run with taps 8,6,5,4 and seed 8'h01 (also its reset value).
REQ-030 Macro PWM_DITHER_EN defined: the LFSR SHALL step once per PWM period at cnt==255.
REQ-031 Macro PWM_DITHER_EN defined: its bit0 SHALL be added to mix_out when loading duty, saturating at 255.
REQ-032 Macro PWM_DITHER_EN undefined: no LFSR logic SHALL exist, and duty SHALL equal mix_out exactly.

Structure
REQ-033 Package audio_pkg SHALL hold the following items:
- typedef sample_t (logic [7:0])
- SILENCE = 8'd128
- PWM_BITS = 8
- default SAMPLE_DIV
REQ-034 PWM counter, duty register, optional dither and pwm_out SHALL live in sub-module pwm_gen.
REQ-035 Divider, capture and mix SHALL remain in audio_pwm_out.

Verification
REQ-036 Tick timing, SAMPLE_DIV=8: release reset -> sample_tick pulses at cycles 8, 16, 24, each 1 cycle wide.
REQ-037 Mix and latency: kick=200, snare=100, voice_en=2'b11, vol_shift=0 -> mix_out=172, 2 cycles after tick.
REQ-038 Saturation and voice disable:
- kick=255, snare=255, vol_shift=0 -> mix_out=255
- kick=0, snare=0 -> mix_out=0
- voice_en=2'b01, kick=128, snare=0 -> mix_out=128
REQ-039 Shift: kick=255, snare=128, vol_shift=2 -> mix_out=159.
REQ-040 PWM duty, dither disabled:
- duty=64 -> 64 high cycles per 256
- duty=0 -> never high
- mix_out change mid-period -> duty unchanged until the cycle after cnt==255
REQ-041 Reset mid-period: rst_n low during cnt=100 with duty=200 -> pwm_out=0 immediately; after release, duty=128 and counters restart from 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio PWM output path.
package audio_pkg;
  typedef logic [7:0] sample_t;

  localparam sample_t SILENCE            = 8'd128;
  localparam int      PWM_BITS           = 8;
  localparam int      DEFAULT_SAMPLE_DIV = 1250;

  // Clamp a 9-bit signed mix to [-128,127] and re-bias to offset-binary.
  function automatic sample_t sat_offset(input logic signed [8:0] v);
    if (v > 9'sd127)       return 8'd255;
    else if (v < -9'sd128) return 8'd0;
    else                   return {~v[7], v[6:0]};
  endfunction
endpackage

// File: rtl/audio_pwm_gen.sv
// PWM generator: free-running 8-bit counter, period-aligned duty load, registered output.
// Optional dither of the duty LSB when PWM_DITHER_EN is defined.
module pwm_gen
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t level,
  output logic    pwm_out
);
  logic [PWM_BITS-1:0] cnt;
  sample_t             duty;
  sample_t             duty_nxt;
  logic                wrap;

  assign wrap = &cnt;

`ifdef PWM_DITHER_EN
  logic [7:0] lfsr;

  always_comb begin
    duty_nxt = level;
    if (lfsr[0] && (level != 8'hFF)) duty_nxt = level + 8'd1;
  end

  // Fibonacci LFSR, taps 8,6,5,4; advances once per PWM period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr <= 8'h01;
    else if (wrap) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign duty_nxt = level;
`endif

  // Duty only changes at the period boundary so a period is never split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      duty    <= SILENCE;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= (cnt < duty);
      if (wrap) duty <= duty_nxt;
    end
  end
endmodule

// File: rtl/audio_pwm_out.sv
// Two-voice audio mixer with sample-rate divider feeding a PWM DAC.
// Build option: PWM_DITHER_EN enables LFSR dither in pwm_gen.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       sample_tick,
  input  logic [7:0] kick_smp,
  input  logic [7:0] snare_smp,
  input  logic [1:0] voice_en,
  input  logic [1:0] vol_shift,
  output logic [7:0] mix_out,
  output logic       pwm_out
);
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0]      div_cnt;
  logic               cap;
  logic signed [8:0]  kick_s, snare_s, sum, scaled;
  sample_t            mix_nxt;

  assign sample_tick = (div_cnt == CW'(SAMPLE_DIV - 1));

  // Offset-binary to signed is an MSB flip; sign-extend to 9 bits for the sum.
  always_comb begin
    kick_s  = '0;
    snare_s = '0;
    if (voice_en[0]) kick_s  = $signed({~kick_smp[7],  ~kick_smp[7],  kick_smp[6:0]});
    if (voice_en[1]) snare_s = $signed({~snare_smp[7], ~snare_smp[7], snare_smp[6:0]});
    sum     = kick_s + snare_s;
    scaled  = sum >>> vol_shift;
    mix_nxt = sat_offset(scaled);
  end

  // Capture one cycle after the tick so the readers' tick-edge outputs are seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      cap     <= 1'b0;
      mix_out <= SILENCE;
    end else begin
      cap     <= sample_tick;
      div_cnt <= sample_tick ? '0 : div_cnt + 1'b1;
      if (cap) mix_out <= mix_nxt;
    end
  end

  pwm_gen u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .level   (mix_out),
    .pwm_out (pwm_out)
  );
endmodule
